send_bytes_tx: RTL and testbench

LED-strip frame driver that sits between the host microcontroller's SPI port and a WS2812-style single-wire LED chain. While `load` is high it captures a fixed-length frame of bytes shifted in on `sck`/`sdi`. When `load` falls it transmits that frame on `datastream` using NRZ pulse-width encoding, then holds the line low for the latch gap.

---
 rtl/send_bytes_tx.sv | 168 ++++++++++++++++
 tb/tb_send_bytes_tx.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/send_bytes_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | send_bytes_tx : SPI-loaded frame buffer driving a WS2812-style NRZ line.  |
// | Option macro SEND_BYTES_TX_REFRESH_EN: retransmit frame after each gap.   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module send_bytes_tx #(
    parameter int N_BYTES = 24,
    parameter int T_BIT   = 50,
    parameter int T0H     = 16,
    parameter int T1H     = 32,
    parameter int T_RES   = 2000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sck,
    input  logic sdi,
    input  logic load,
    output logic datastream
);

    localparam int TOTAL_BITS = N_BYTES * 8;
    localparam int CNT_MAX    = (T_BIT > T_RES) ? T_BIT : T_RES;
    localparam int CW         = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int BW         = (TOTAL_BITS > 1) ? $clog2(TOTAL_BITS) : 1;

    localparam logic [CW-1:0] C_BIT_END = CW'(T_BIT - 1);
    localparam logic [CW-1:0] C_RES_END = CW'(T_RES - 1);
    localparam logic [CW-1:0] C_T0H     = CW'(T0H);
    localparam logic [CW-1:0] C_T1H     = CW'(T1H);
    localparam logic [BW-1:0] C_IDX_TOP = BW'(TOTAL_BITS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SEND  = 2'd1;
    localparam logic [1:0] S_LATCH = 2'd2;

    logic                  r_sck_meta, r_sck_sync, r_sck_prev;
    logic                  r_sdi_meta, r_sdi_sync;
    logic                  r_load_meta, r_load_sync, r_load_prev;
    logic [TOTAL_BITS-1:0] r_rx;
    logic [TOTAL_BITS-1:0] r_tx;
    logic                  r_pending;
    logic [1:0]            r_state;
    logic [BW-1:0]         r_idx;
    logic [CW-1:0]         r_cyc;
    logic                  r_ds;

    logic                  w_sck_rise;
    logic                  w_load_fall;
    logic [1:0]            w_state_nx;
    logic [BW-1:0]         w_idx_nx;
    logic [CW-1:0]         w_cyc_nx;
    logic                  w_load_tx;
    logic [TOTAL_BITS-1:0] w_tx_nx;
    logic [CW-1:0]         w_hi_len;
    logic                  w_ds_nx;

    assign w_sck_rise  = r_sck_sync & ~r_sck_prev;
    assign w_load_fall = r_load_prev & ~r_load_sync;
    assign datastream  = r_ds;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sck_meta  <= 1'b0;
            r_sck_sync  <= 1'b0;
            r_sck_prev  <= 1'b0;
            r_sdi_meta  <= 1'b0;
            r_sdi_sync  <= 1'b0;
            r_load_meta <= 1'b0;
            r_load_sync <= 1'b0;
            r_load_prev <= 1'b0;
            r_rx        <= '0;
            r_pending   <= 1'b0;
        end else begin
            r_sck_meta  <= sck;
            r_sck_sync  <= r_sck_meta;
            r_sck_prev  <= r_sck_sync;
            r_sdi_meta  <= sdi;
            r_sdi_sync  <= r_sdi_meta;
            r_load_meta <= load;
            r_load_sync <= r_load_meta;
            r_load_prev <= r_load_sync;
            if (w_sck_rise && r_load_sync) begin
                r_rx <= {r_rx[TOTAL_BITS-2:0], r_sdi_sync};
            end
            // A new fall wins over a same-cycle hand-off so the latest data is never lost
            if (w_load_fall) begin
                r_pending <= 1'b1;
            end else if (w_load_tx) begin
                r_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_cyc   <= '0;
            r_tx    <= '0;
            r_ds    <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_idx   <= w_idx_nx;
            r_cyc   <= w_cyc_nx;
            r_tx    <= w_tx_nx;
            r_ds    <= w_ds_nx;
        end
    end

    // Bit index counts down so it addresses the transmit register MSB first
    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        w_cyc_nx   = r_cyc;
        w_load_tx  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_pending) begin
                    w_state_nx = S_SEND;
                    w_load_tx  = 1'b1;
                    w_idx_nx   = C_IDX_TOP;
                    w_cyc_nx   = '0;
                end
            end
            S_SEND: begin
                if (r_cyc == C_BIT_END) begin
                    w_cyc_nx = '0;
                    if (r_idx == '0) begin
                        w_state_nx = S_LATCH;
                    end else begin
                        w_idx_nx = r_idx - 1'b1;
                    end
                end else begin
                    w_cyc_nx = r_cyc + 1'b1;
                end
            end
            S_LATCH: begin
                if (r_cyc == C_RES_END) begin
                    w_cyc_nx = '0;
                    w_idx_nx = C_IDX_TOP;
`ifdef SEND_BYTES_TX_REFRESH_EN
                    w_state_nx = S_SEND;
                    w_load_tx  = r_pending;
`else
                    w_state_nx = S_IDLE;
`endif
                end else begin
                    w_cyc_nx = r_cyc + 1'b1;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_idx_nx   = '0;
                w_cyc_nx   = '0;
            end
        endcase
    end

    // Output is computed from the next state so the line is a clean register
    always_comb begin
        w_tx_nx  = w_load_tx ? r_rx : r_tx;
        w_hi_len = w_tx_nx[w_idx_nx] ? C_T1H : C_T0H;
        w_ds_nx  = (w_state_nx == S_SEND) && (w_cyc_nx < w_hi_len);
    end

endmodule
`default_nettype wire

// File: tb/tb_send_bytes_tx.sv
`default_nettype none
// tb_send_bytes_tx: randomized frame bench for send_bytes_tx (3-byte build)
// against a waveform model derived from the received-bit history.
module tb_send_bytes_tx;

    localparam int N_BYTES = 3;
    localparam int T_BIT   = 50;
    localparam int T0H     = 16;
    localparam int T1H     = 32;
    localparam int T_RES   = 2000;
    localparam int NBITS   = N_BYTES * 8;
    localparam int FRAME   = NBITS * T_BIT + T_RES;
    localparam int LAT     = 4;
`ifdef SEND_BYTES_TX_REFRESH_EN
    localparam logic POST_EXP = 1'b1;
    localparam int   GAP2     = 0;
`else
    localparam logic POST_EXP = 1'b0;
    localparam int   GAP2     = 1;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic sck = 1'b0;
    logic sdi = 1'b0;
    logic load = 1'b0;
    logic datastream;

    logic obs[$];
    bit   hist[$];
    int   checks = 0;
    int   errors = 0;

    send_bytes_tx #(
        .N_BYTES(N_BYTES), .T_BIT(T_BIT), .T0H(T0H), .T1H(T1H), .T_RES(T_RES)
    ) dut (
        .clk(clk), .reset_n(reset_n), .sck(sck), .sdi(sdi), .load(load),
        .datastream(datastream)
    );

    always #5 clk = ~clk;

    // Frame = last NBITS received bits since reset, zero-padded when fewer
    function automatic logic [NBITS-1:0] model_frame();
        logic [NBITS-1:0] f = '0;
        int n = hist.size();
        for (int k = 0; k < NBITS; k++) begin
            int src = n - NBITS + k;
            f[NBITS-1-k] = (src >= 0) ? hist[src] : 1'b0;
        end
        return f;
    endfunction

    function automatic int high_cnt(input int base, input int b);
        int h = 0;
        for (int c = 0; c < T_BIT; c++) if (obs[base + b*T_BIT + c] === 1'b1) h++;
        return h;
    endfunction

    // Number of bit windows whose sampled waveform differs from the ideal NRZ pulse
    function automatic int frame_bad(input int base, input logic [NBITS-1:0] f,
                                     output int first);
        int bad = 0;
        first = -1;
        for (int b = 0; b < NBITS; b++) begin
            int hi = f[NBITS-1-b] ? T1H : T0H;
            int m = 0;
            for (int c = 0; c < T_BIT; c++)
                if (obs[base + b*T_BIT + c] !== ((c < hi) ? 1'b1 : 1'b0)) m++;
            if (m != 0) begin
                if (first < 0) first = b;
                bad++;
            end
        end
        return bad;
    endfunction

    function automatic int latch_highs(input int base);
        int h = 0;
        for (int c = 0; c < T_RES; c++) if (obs[base + NBITS*T_BIT + c] !== 1'b0) h++;
        return h;
    endfunction

    task automatic do_reset();
        @(posedge clk); #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (3) @(posedge clk);
        hist.delete();
    endtask

    task automatic spi_bit(input bit b);
        @(posedge clk); #1 sdi = b;
        repeat (3) @(posedge clk);
        #1 sck = 1'b1;
        repeat (4) @(posedge clk);
        #1 sck = 1'b0;
        hist.push_back(b);
    endtask

    task automatic raise_load();
        @(posedge clk); #1 load = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    task automatic drop_load();
        repeat (3) @(posedge clk);
        @(posedge clk); #1 load = 1'b0;
    endtask

    task automatic record(input int n);
        obs.delete();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            obs.push_back(datastream);
        end
    endtask

    task automatic test_reset();
        logic [NBITS-1:0] f;
        int q = 0;
        do_reset();
        checks++;
        if (datastream !== 1'b0) begin
            errors++; $display("FAIL reset_state: datastream=%b expected 0", datastream);
        end
        raise_load();
        for (int i = 0; i < NBITS; i++) spi_bit(1'(($urandom % 4) != 0));
        f = model_frame();
        drop_load();
        repeat (LAT + 100) @(posedge clk);
        #2;
        checks++;
        if (datastream !== 1'b1) begin
            errors++; $display("FAIL pre_reset_high: datastream=%b expected 1", datastream);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (datastream !== 1'b0) begin
            errors++; $display("FAIL async_reset: datastream=%b expected 0", datastream);
        end
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        hist.delete();
        for (int i = 0; i < FRAME + 100; i++) begin
            @(negedge clk);
            if (datastream !== 1'b0) q++;
        end
        checks++;
        if (q !== 0) begin
            errors++; $display("FAIL quiet_after_reset: %0d high cycles expected 0 (old frame %h)", q, f);
        end
    endtask

    task automatic test_no_data();
        int bad, first, base;
        logic [NBITS-1:0] f;
        @(posedge clk); #1 load = 1'b1;
        repeat (2) @(posedge clk);
        #1 load = 1'b0;
        f = model_frame();
        record(LAT + FRAME + 2);
        base = LAT;
        checks++;
        if ({obs[LAT-1], obs[LAT]} !== 2'b01) begin
            errors++; $display("FAIL no_data_latency: edge=%b%b expected 01", obs[LAT-1], obs[LAT]);
        end
        bad = frame_bad(base, f, first);
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL no_data_bits: %0d bad bits, bit %0d high=%0d expected %0d",
                               bad, first, high_cnt(base, first), T0H);
        end
        checks++;
        if (latch_highs(base) !== 0) begin
            errors++; $display("FAIL no_data_latch: %0d high cycles expected 0", latch_highs(base));
        end
        checks++;
        if (obs[base + FRAME] !== POST_EXP) begin
            errors++; $display("FAIL no_data_post: datastream=%b expected %b", obs[base + FRAME], POST_EXP);
        end
    endtask

    task automatic test_pattern();
        logic [NBITS-1:0] f;
        logic [7:0] bytes_q [3];
        int bad, first, base;
        do_reset();
        f = 24'hFF00A5;
        bytes_q[0] = 8'hFF; bytes_q[1] = 8'h00; bytes_q[2] = 8'hA5;
        raise_load();
        for (int i = 0; i < 3; i++)
            for (int j = 7; j >= 0; j--) spi_bit(bytes_q[i][j]);
        drop_load();
        record(LAT + FRAME + 2);
        base = LAT;
        checks++;
        if ({obs[LAT-1], obs[LAT]} !== 2'b01) begin
            errors++; $display("FAIL pattern_latency: edge=%b%b expected 01", obs[LAT-1], obs[LAT]);
        end
        bad = frame_bad(base, f, first);
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL pattern_bits: %0d bad bits, bit %0d high=%0d expected %0d",
                               bad, first, high_cnt(base, first), f[NBITS-1-first] ? T1H : T0H);
        end
        checks++;
        if (latch_highs(base) !== 0) begin
            errors++; $display("FAIL pattern_latch: %0d high cycles expected 0", latch_highs(base));
        end
        checks++;
        if (obs[base + FRAME] !== POST_EXP) begin
            errors++; $display("FAIL pattern_post: datastream=%b expected %b", obs[base + FRAME], POST_EXP);
        end
    endtask

    task automatic test_random_frames();
        logic [NBITS-1:0] f;
        int bad, first, base, nb;
        for (int it = 0; it < 3; it++) begin
`ifdef SEND_BYTES_TX_REFRESH_EN
            do_reset();
`endif
            nb = $urandom_range(40, 4);
            raise_load();
            for (int i = 0; i < nb; i++) spi_bit(1'($urandom % 2));
            f = model_frame();
            drop_load();
            record(LAT + FRAME + 2);
            base = LAT;
            checks++;
            if ({obs[LAT-1], obs[LAT]} !== 2'b01) begin
                errors++; $display("FAIL random_latency[%0d]: edge=%b%b expected 01", it, obs[LAT-1], obs[LAT]);
            end
            bad = frame_bad(base, f, first);
            checks++;
            if (bad !== 0) begin
                errors++; $display("FAIL random_bits[%0d]: nbits=%0d frame=%h %0d bad bits, bit %0d high=%0d expected %0d",
                                   it, nb, f, bad, first, high_cnt(base, first), f[NBITS-1-first] ? T1H : T0H);
            end
            checks++;
            if (latch_highs(base) !== 0) begin
                errors++; $display("FAIL random_latch[%0d]: %0d high cycles expected 0", it, latch_highs(base));
            end
            checks++;
            if (obs[base + FRAME] !== POST_EXP) begin
                errors++; $display("FAIL random_post[%0d]: datastream=%b expected %b", it, obs[base + FRAME], POST_EXP);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [NBITS-1:0] fa, fb;
        int bad, first, base_b;
        do_reset();
        raise_load();
        for (int i = 0; i < NBITS; i++) spi_bit(1'($urandom % 2));
        fa = model_frame();
        drop_load();
        fork
            record(LAT + FRAME + GAP2 + FRAME + 4);
            begin
                repeat (700) @(posedge clk);
                for (int r = 0; r < 2; r++) begin
                    raise_load();
                    for (int i = 0; i < NBITS; i++) spi_bit(1'($urandom % 2));
                    drop_load();
                    repeat (50) @(posedge clk);
                end
            end
        join
        fb = model_frame();
        base_b = LAT + FRAME + GAP2;
        bad = frame_bad(LAT, fa, first);
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL b2b_first_bits: frame=%h %0d bad bits, bit %0d high=%0d",
                               fa, bad, first, high_cnt(LAT, first));
        end
        checks++;
        if (latch_highs(LAT) !== 0) begin
            errors++; $display("FAIL b2b_first_latch: %0d high cycles expected 0", latch_highs(LAT));
        end
        checks++;
        if ({obs[base_b-1], obs[base_b]} !== 2'b01) begin
            errors++; $display("FAIL b2b_second_start: edge=%b%b expected 01", obs[base_b-1], obs[base_b]);
        end
        bad = frame_bad(base_b, fb, first);
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL b2b_second_bits: frame=%h %0d bad bits, bit %0d high=%0d expected %0d",
                               fb, bad, first, high_cnt(base_b, first), fb[NBITS-1-first] ? T1H : T0H);
        end
        checks++;
        if (latch_highs(base_b) !== 0) begin
            errors++; $display("FAIL b2b_second_latch: %0d high cycles expected 0", latch_highs(base_b));
        end
        checks++;
        if (obs[base_b + FRAME] !== POST_EXP) begin
            errors++; $display("FAIL b2b_post: datastream=%b expected %b", obs[base_b + FRAME], POST_EXP);
        end
    endtask

    initial begin
        test_reset();
        test_no_data();
        test_pattern();
        test_random_frames();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
